// File: rtl/rx_frame_loader.sv
// Loads one length-prefixed frame from UART_RX into data RAM.
// Optional inter-byte timeout is built when TIMEOUT_EN is defined.
module rx_frame_loader #(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter logic [15:0] MAX_LEN     = 16'hFFFF,
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_done,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_din,
   output logic        ram_we,
   output logic        busy,
   output logic [15:0] frame_len,
   output logic        load_done,
   output logic        err_len,
   output logic        err_timeout
);

   typedef enum logic [1:0] {
      IDLE,
      LEN_LO,
      DATA,
      DONE
   } state_t;

   state_t      state, state_n;
   logic [7:0]  hi_q, hi_n;
   logic [15:0] len_q, len_n;
   logic [15:0] cnt_q, cnt_n;
   logic [15:0] addr_n;
   logic [7:0]  din_n;
   logic        we_n;
   logic        busy_n;
   logic [15:0] flen_n;
   logic        done_n;
   logic        elen_n;
   logic        eto_n;
   logic [15:0] len_w;

   assign len_w = {hi_q, rx_byte};

`ifdef TIMEOUT_EN
   logic [31:0] idle_q, idle_n;
`endif

   always_comb begin
      state_n = state;
      hi_n    = hi_q;
      len_n   = len_q;
      cnt_n   = cnt_q;
      addr_n  = ram_addr;
      din_n   = ram_din;
      we_n    = 1'b0;
      busy_n  = busy;
      flen_n  = frame_len;
      done_n  = 1'b0;
      elen_n  = 1'b0;
      eto_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_done) begin
               hi_n    = rx_byte;
               busy_n  = 1'b1;
               state_n = LEN_LO;
            end
         end
         LEN_LO: begin
            if (rx_done) begin
               flen_n = len_w;
               len_n  = len_w;
               if (len_w == 16'd0) begin
                  state_n = DONE;
               end else if (len_w > MAX_LEN) begin
                  elen_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end else begin
                  cnt_n   = 16'd0;
                  state_n = DATA;
               end
            end
         end
         DATA: begin
            if (rx_done) begin
               we_n   = 1'b1;
               addr_n = BASE_ADDR + cnt_q;
               din_n  = rx_byte;
               cnt_n  = cnt_q + 16'd1;
               if (cnt_q == len_q - 16'd1)
                  state_n = DONE;
            end
         end
         DONE: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
`ifdef TIMEOUT_EN
      // idle_q counts silent cycles since the last accepted byte
      idle_n = 32'd0;
      if ((state == LEN_LO || state == DATA) && !rx_done) begin
         if (idle_q == TIMEOUT_CYC - 32'd2) begin
            eto_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end else begin
            idle_n = idle_q + 32'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hi_q        <= 8'd0;
         len_q       <= 16'd0;
         cnt_q       <= 16'd0;
         ram_addr    <= 16'd0;
         ram_din     <= 8'd0;
         ram_we      <= 1'b0;
         busy        <= 1'b0;
         frame_len   <= 16'd0;
         load_done   <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_n;
         hi_q        <= hi_n;
         len_q       <= len_n;
         cnt_q       <= cnt_n;
         ram_addr    <= addr_n;
         ram_din     <= din_n;
         ram_we      <= we_n;
         busy        <= busy_n;
         frame_len   <= flen_n;
         load_done   <= done_n;
         err_len     <= elen_n;
         err_timeout <= eto_n;
      end
   end

`ifdef TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         idle_q <= 32'd0;
      else
         idle_q <= idle_n;
   end
`endif

endmodule
